// File: rtl/regfile_read_sequencer.sv
// Source-operand read sequencer for the two-port register file. It reads rs/rt in
// one cycle and optionally rd on port 1, then returns the forwarded operands over valid/ready.
module regfile_read_sequencer #(
   parameter int DATA_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [1:0]         num_src,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [4:0]         instr25_21,
   output logic [4:0]         instr20_16,
   output logic [4:0]         instr15_11,
   output logic               read1or3,
   input  logic [DATA_W-1:0]  rd1_data,
   input  logic [DATA_W-1:0]  rd2_data,
   input  logic               wb_en,
   input  logic [4:0]         wb_addr,
   input  logic [DATA_W-1:0]  wb_data,
   output logic [DATA_W-1:0]  op_a,
   output logic [DATA_W-1:0]  op_b,
   output logic [DATA_W-1:0]  op_c,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               busy
);

   typedef enum logic [1:0] {IDLE, RD_AB, RD_C, DONE} state_t;

   state_t            state_q;
   logic [4:0]        rs_q, rt_q, rd_q;
   logic [1:0]        nsrc_q;
   logic [DATA_W-1:0] op_a_q, op_b_q, op_c_q;
   logic              in_ready_q, out_valid_q, busy_q, read1or3_q;

   // Only the three register fields of the instruction are kept.
   logic unused_instr_bits;
   assign unused_instr_bits = ^{instr_in[INSTR_W-1:26], instr_in[10:0]};

   function automatic logic [DATA_W-1:0] fwd(input logic [4:0] addr, input logic [DATA_W-1:0] d);
      if (addr == 5'd0)                    return '0;
      else if (wb_en && wb_addr == addr)  return wb_data;
      else                                 return d;
   endfunction

   // Handshake/mux flags are flops set alongside the state so they never glitch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rs_q        <= '0;
         rt_q        <= '0;
         rd_q        <= '0;
         nsrc_q      <= '0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_c_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         read1or3_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               rs_q       <= instr_in[25:21];
               rt_q       <= instr_in[20:16];
               rd_q       <= instr_in[15:11];
               nsrc_q     <= num_src;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b1;
               if (num_src == 2'd0) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end else begin
                  state_q <= RD_AB;
               end
            end
            RD_AB: begin
               op_a_q <= (nsrc_q >= 2'd1) ? fwd(rs_q, rd1_data) : '0;
               op_b_q <= (nsrc_q >= 2'd2) ? fwd(rt_q, rd2_data) : '0;
               op_c_q <= '0;
               if (nsrc_q == 2'd3) begin
                  state_q    <= RD_C;
                  read1or3_q <= 1'b1;
               end else begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b1;
               end
            end
            RD_C: begin
               op_c_q      <= fwd(rd_q, rd1_data);
               state_q     <= DONE;
               read1or3_q  <= 1'b0;
               out_valid_q <= 1'b1;
            end
            DONE: if (out_ready) begin
               state_q     <= IDLE;
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               busy_q      <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign busy       = busy_q;
   assign read1or3   = read1or3_q;
   assign instr25_21 = rs_q;
   assign instr20_16 = rt_q;
   assign instr15_11 = rd_q;
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign op_c       = op_c_q;

endmodule

// File: tb/tb_regfile_read_sequencer.sv
// Bench for regfile_read_sequencer: vector table plus scoreboard of expected operands,
// with hand sequences for reset during RD_C and in_valid while busy.
module tb_regfile_read_sequencer;
   localparam int DATA_W = 32;
   localparam int INSTR_W = 32;

   logic               clk = 1'b0;
   logic               reset;
   logic [INSTR_W-1:0] instr_in;
   logic [1:0]         num_src;
   logic               in_valid;
   logic               in_ready;
   logic [4:0]         instr25_21, instr20_16, instr15_11;
   logic               read1or3;
   logic [DATA_W-1:0]  rd1_data, rd2_data;
   logic               wb_en;
   logic [4:0]         wb_addr;
   logic [DATA_W-1:0]  wb_data;
   logic [DATA_W-1:0]  op_a, op_b, op_c;
   logic               out_valid;
   logic               out_ready;
   logic               busy;

   regfile_read_sequencer #(.DATA_W(DATA_W), .INSTR_W(INSTR_W)) dut (
      .clk(clk), .reset(reset), .instr_in(instr_in), .num_src(num_src),
      .in_valid(in_valid), .in_ready(in_ready), .instr25_21(instr25_21),
      .instr20_16(instr20_16), .instr15_11(instr15_11), .read1or3(read1or3),
      .rd1_data(rd1_data), .rd2_data(rd2_data), .wb_en(wb_en), .wb_addr(wb_addr),
      .wb_data(wb_data), .op_a(op_a), .op_b(op_b), .op_c(op_c),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

   always #5 clk = ~clk;

   // Register file contents (never written: forwarding must supply fresh values).
   logic [DATA_W-1:0] regs [32];
   always_comb begin
      rd1_data = regs[read1or3 ? instr15_11 : instr25_21];
      rd2_data = regs[instr20_16];
   end

   typedef struct {
      logic [1:0]  ns;
      logic [4:0]  rs, rt, rd;
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      int          stall;
      logic        chk_ops;
      logic [31:0] a, b, c;
      int          lat;
   } vec_t;

   typedef struct { logic [31:0] a, b, c; logic chk; } exp_t;

   vec_t vecs [9];
   exp_t sb [$];
   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'h0, rs, rt, rd, 11'h0};
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      int   k, r13;
      @(negedge clk);
      instr_in  = mk(v.rs, v.rt, v.rd);
      num_src   = v.ns;
      in_valid  = 1'b1;
      out_ready = (v.stall == 0);
      sb.push_back('{a: v.a, b: v.b, c: v.c, chk: v.chk_ops});
      @(posedge clk); #1;
      in_valid = 1'b0;
      wb_en    = v.wen;
      wb_addr  = v.waddr;
      wb_data  = v.wdata;
      check($sformatf("v%0d in_ready_after_accept", idx), in_ready, 0);
      check($sformatf("v%0d rs_field", idx), instr25_21, v.rs);
      k = 1; r13 = 0;
      while (!out_valid && k < 10) begin
         @(posedge clk); #1;
         if (k == 1) wb_en = 1'b0;
         if (read1or3) r13++;
         k++;
      end
      wb_en = 1'b0;
      if (!out_valid) begin
         n_chk++; n_fail++;
         $display("FAIL v%0d out_valid_timeout: got 0 expected 1", idx);
      end
      check($sformatf("v%0d latency", idx), k, v.lat);
      check($sformatf("v%0d read1or3_cycles", idx), r13, (v.ns == 2'd3) ? 1 : 0);
      e = sb.pop_front();
      if (e.chk) begin
         check($sformatf("v%0d op_a", idx), op_a, e.a);
         check($sformatf("v%0d op_b", idx), op_b, e.b);
         check($sformatf("v%0d op_c", idx), op_c, e.c);
      end
      for (int s = 0; s < v.stall; s++) begin
         wb_en = 1'b1; wb_addr = v.rs; wb_data = 32'hF00D;
         @(posedge clk); #1;
         check($sformatf("v%0d stall_out_valid", idx), out_valid, 1);
         check($sformatf("v%0d stall_in_ready", idx), in_ready, 0);
         check($sformatf("v%0d stall_op_a", idx), op_a, e.a);
         check($sformatf("v%0d stall_op_b", idx), op_b, e.b);
      end
      wb_en = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check($sformatf("v%0d idle_in_ready", idx), in_ready, 1);
      check($sformatf("v%0d idle_out_valid", idx), out_valid, 0);
      check($sformatf("v%0d idle_busy", idx), busy, 0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
      regs[0] = 32'hBAD0; regs[1] = 32'h101; regs[2] = 32'h202;
      regs[3] = 32'h11;   regs[4] = 32'h22;  regs[5] = 32'hDEAD; regs[7] = 32'h7;

      //             ns    rs  rt  rd  wen waddr wdata     stall chk  a          b       c        lat
      vecs[0] = '{2'd2, 3, 4, 0, 0, 0, 0,          0, 1, 32'h11,   32'h22, 32'h0,    2};
      vecs[1] = '{2'd3, 1, 2, 5, 0, 0, 0,          0, 1, 32'h101,  32'h202,32'hDEAD, 3};
      vecs[2] = '{2'd2, 3, 4, 0, 1, 3, 32'hBEEF,   0, 1, 32'hBEEF, 32'h22, 32'h0,    2};
      vecs[3] = '{2'd2, 0, 4, 0, 1, 0, 32'hBEEF,   0, 1, 32'h0,    32'h22, 32'h0,    2};
      vecs[4] = '{2'd2, 3, 4, 0, 0, 0, 0,          5, 1, 32'h11,   32'h22, 32'h0,    2};
      vecs[5] = '{2'd0, 3, 4, 5, 0, 0, 0,          0, 0, 32'h0,    32'h0,  32'h0,    1};
      vecs[6] = '{2'd1, 7, 4, 5, 0, 0, 0,          0, 1, 32'h7,    32'h0,  32'h0,    2};
      vecs[7] = '{2'd3, 2, 3, 0, 1, 2, 32'h5A5A,   0, 1, 32'h5A5A, 32'h11, 32'h0,    3};
      vecs[8] = '{2'd2, 0, 0, 0, 0, 0, 0,          0, 1, 32'h0,    32'h0,  32'h0,    2};

      reset = 1'b1; instr_in = '0; num_src = '0; in_valid = 1'b0;
      wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst in_ready", in_ready, 1);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
      check("rst read1or3", read1or3, 0);
      check("rst op_a", op_a, 0);
      check("rst rs_field", instr25_21, 0);
      @(negedge clk); reset = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // in_valid while busy must not relatch the instruction.
      @(negedge clk);
      instr_in = mk(5'd3, 5'd4, 5'd0); num_src = 2'd2; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      instr_in = mk(5'd7, 5'd7, 5'd7); num_src = 2'd3;
      repeat (3) @(posedge clk);
      #1;
      check("busy_ignore rs_field", instr25_21, 3);
      check("busy_ignore rt_field", instr20_16, 4);
      check("busy_ignore op_a", op_a, 32'h11);
      check("busy_ignore out_valid", out_valid, 1);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      check("busy_ignore idle", in_ready, 1);

      // Reset while in RD_C discards the instruction.
      @(negedge clk);
      instr_in = mk(5'd1, 5'd2, 5'd5); num_src = 2'd3; in_valid = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(posedge clk); #1;
      check("rdc read1or3", read1or3, 1);
      check("rdc op_a_loaded", op_a, 32'h101);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rdc_rst in_ready", in_ready, 1);
      check("rdc_rst out_valid", out_valid, 0);
      check("rdc_rst busy", busy, 0);
      check("rdc_rst read1or3", read1or3, 0);
      check("rdc_rst op_a", op_a, 0);
      check("rdc_rst op_b", op_b, 0);
      check("rdc_rst op_c", op_c, 0);
      @(negedge clk); reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rdc_rst no_out_valid", out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
